// File: rtl/tqvp_jnms_pdm_tx_if.sv
// Register bus between the TinyQV core and the PDM transmit peripheral.
// The master drives address, write data and the strobes; the slave returns read data.
interface tqvp_jnms_pdm_tx_if;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;

    modport master (
        output address, data_in, data_write_n, data_read_n,
        input  data_out, data_ready
    );

    modport slave (
        input  address, data_in, data_write_n, data_read_n,
        output data_out, data_ready
    );
endinterface

// File: rtl/tqvp_jnms_pdm_tx.sv
// PCM-to-PDM transmitter: 4-entry sample FIFO, clock divider and a delta-sigma modulator.
// Define PDM_TX_ORDER2_EN to select the second-order error-feedback modulator.
module tqvp_jnms_pdm_tx (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        ui_in,
    output logic [7:0]        uo_out,
    tqvp_jnms_pdm_tx_if.slave bus,
    output logic              user_interrupt
);

    localparam logic [5:0] ADDR_CTRL   = 6'h00;
    localparam logic [5:0] ADDR_PERIOD = 6'h04;
    localparam logic [5:0] ADDR_SAMPLE = 6'h08;
    localparam logic [5:0] ADDR_STATUS = 6'h0C;
    localparam logic [5:0] ADDR_OSR    = 6'h10;

    logic        enable_r;
    logic [7:0]  period_r;
    logic [7:0]  osr_r;
    logic [7:0]  phase_r;
    logic [7:0]  bit_cnt_r;
    logic        pdm_clk_r;
    logic        pdm_data_r;
    logic [15:0] cur_sample_r;
    logic [15:0] fifo_mem_r [0:3];
    logic [1:0]  wr_ptr_r;
    logic [1:0]  rd_ptr_r;
    logic [2:0]  level_r;
    logic        underflow_r;
    logic        overflow_r;

    logic        write_s;
    logic        active_s;
    logic [7:0]  half_s;
    logic        step_s;
    logic        load_s;
    logic        pop_s;
    logic        push_s;
    logic        push_ok_s;
    logic        status_wr_s;
    logic        unf_set_s;
    logic        ovf_set_s;
    logic [8:0]  osr_eff_s;
    logic [8:0]  bit_cnt_inc_s;
    logic [15:0] sample_s;
    logic        mod_bit_s;
    logic        unused_s;

    assign write_s       = (bus.data_write_n != 2'b11);
    assign active_s      = enable_r & (period_r >= 8'd2);
    assign half_s        = {1'b0, period_r[7:1]};
    assign step_s        = active_s & (phase_r == half_s);
    assign load_s        = step_s & (bit_cnt_r == 8'd0);
    assign pop_s         = load_s & (level_r != 3'd0);
    assign push_s        = write_s & (bus.address == ADDR_SAMPLE);
    // A full FIFO still accepts a push when the same cycle pops the head.
    assign push_ok_s     = push_s & ((level_r != 3'd4) | pop_s);
    assign status_wr_s   = write_s & (bus.address == ADDR_STATUS);
    assign unf_set_s     = load_s & (level_r == 3'd0);
    assign ovf_set_s     = push_s & (level_r == 3'd4) & ~pop_s;
    assign osr_eff_s     = (osr_r == 8'd0) ? 9'd256 : {1'b0, osr_r};
    assign bit_cnt_inc_s = {1'b0, bit_cnt_r} + 9'd1;
    assign sample_s      = pop_s ? fifo_mem_r[rd_ptr_r] : cur_sample_r;

    assign uo_out         = {5'd0, pdm_data_r, pdm_clk_r, 1'b0};
    assign user_interrupt = enable_r & (level_r <= 3'd1);
    assign bus.data_ready = 1'b1;
    assign unused_s       = ^{ui_in, bus.data_read_n, bus.data_in[31:16]};

`ifdef PDM_TX_ORDER2_EN
    logic signed [19:0] i1_r;
    logic signed [23:0] i2_r;
    logic signed [19:0] i1_next_s;
    logic signed [23:0] i2_next_s;
    logic signed [25:0] fb_s;
    logic signed [25:0] sum1_s;
    logic signed [25:0] sum2_s;

    function automatic logic signed [19:0] sat20(input logic signed [25:0] v);
        if (v > 26'sd524287) begin
            return 20'sd524287;
        end else if (v < -26'sd524288) begin
            return -20'sd524288;
        end else begin
            return v[19:0];
        end
    endfunction

    function automatic logic signed [23:0] sat24(input logic signed [25:0] v);
        if (v > 26'sd8388607) begin
            return 24'sd8388607;
        end else if (v < -26'sd8388608) begin
            return -24'sd8388608;
        end else begin
            return v[23:0];
        end
    endfunction

    // Second-order error feedback; the feedback level follows the previous output bit.
    always_comb begin
        fb_s      = pdm_data_r ? 26'sd32767 : -26'sd32768;
        sum1_s    = $signed({{10{sample_s[15]}}, sample_s}) + $signed({{6{i1_r[19]}}, i1_r}) - fb_s;
        i1_next_s = sat20(sum1_s);
        sum2_s    = $signed({{2{i2_r[23]}}, i2_r}) + $signed({{6{i1_next_s[19]}}, i1_next_s}) - fb_s;
        i2_next_s = sat24(sum2_s);
        mod_bit_s = ~i2_next_s[23];
    end
`else
    logic [15:0] acc_r;
    logic [16:0] acc_sum_s;

    // First-order accumulator: offset-binary sample added each bit, carry is the output.
    always_comb begin
        acc_sum_s = {1'b0, acc_r} + {1'b0, sample_s ^ 16'h8000};
        mod_bit_s = acc_sum_s[16];
    end
`endif

    // Software-visible configuration registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enable_r <= 1'b0;
            period_r <= 8'd0;
            osr_r    <= 8'd0;
        end else if (write_s) begin
            case (bus.address)
                ADDR_CTRL:   enable_r <= bus.data_in[0];
                ADDR_PERIOD: period_r <= bus.data_in[7:0];
                ADDR_OSR:    osr_r    <= bus.data_in[7:0];
                default: begin
                end
            endcase
        end
    end

    // Sample FIFO storage, pointers and fill level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                fifo_mem_r[i] <= 16'd0;
            end
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            level_r  <= 3'd0;
        end else begin
            if (push_ok_s) begin
                fifo_mem_r[wr_ptr_r] <= bus.data_in[15:0];
                wr_ptr_r             <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            case ({push_ok_s, pop_s})
                2'b10:   level_r <= level_r + 3'd1;
                2'b01:   level_r <= level_r - 3'd1;
                default: level_r <= level_r;
            endcase
        end
    end

    // Sticky error flags; a new event in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            underflow_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            underflow_r <= unf_set_s | (underflow_r & ~(status_wr_s & bus.data_in[8]));
            overflow_r  <= ovf_set_s | (overflow_r & ~(status_wr_s & bus.data_in[9]));
        end
    end

    // Divider, bit counter and modulator; everything collapses to 0 while inactive.
    always_ff @(posedge clk) begin
        if (!rst_n || !active_s) begin
            phase_r      <= 8'd0;
            pdm_clk_r    <= 1'b0;
            pdm_data_r   <= 1'b0;
            bit_cnt_r    <= 8'd0;
            cur_sample_r <= 16'd0;
`ifdef PDM_TX_ORDER2_EN
            i1_r         <= 20'sd0;
            i2_r         <= 24'sd0;
`else
            acc_r        <= 16'd0;
`endif
        end else begin
            phase_r   <= (phase_r >= period_r - 8'd1) ? 8'd0 : phase_r + 8'd1;
            pdm_clk_r <= (phase_r < half_s);
            if (step_s) begin
                cur_sample_r <= sample_s;
                pdm_data_r   <= mod_bit_s;
                bit_cnt_r    <= (bit_cnt_inc_s >= osr_eff_s) ? 8'd0 : bit_cnt_inc_s[7:0];
`ifdef PDM_TX_ORDER2_EN
                i1_r         <= i1_next_s;
                i2_r         <= i2_next_s;
`else
                acc_r        <= acc_sum_s[15:0];
`endif
            end
        end
    end

    // Side-effect-free register read mux.
    always_comb begin
        bus.data_out = 32'd0;
        case (bus.address)
            ADDR_CTRL:   bus.data_out = {31'd0, enable_r};
            ADDR_PERIOD: bus.data_out = {24'd0, period_r};
            ADDR_SAMPLE: bus.data_out = {{16{cur_sample_r[15]}}, cur_sample_r};
            ADDR_STATUS: bus.data_out = {22'd0, overflow_r, underflow_r, 5'd0, level_r};
            ADDR_OSR:    bus.data_out = {24'd0, osr_r};
            default:     bus.data_out = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_tqvp_jnms_pdm_tx.sv
// Bench for tqvp_jnms_pdm_tx: directed and randomized register traffic checked every
// cycle against a sample-level reference model (queue FIFO, arithmetic modulator).
module tb_tqvp_jnms_pdm_tx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ui_in = 8'd0;
    logic [7:0] uo_out;
    logic       user_interrupt;

    tqvp_jnms_pdm_tx_if bus ();

    tqvp_jnms_pdm_tx dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ui_in          (ui_in),
        .uo_out         (uo_out),
        .bus            (bus.slave),
        .user_interrupt (user_interrupt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit          m_en;
    int          m_period;
    int          m_osr;
    int          m_t;
    int          m_bitidx;
    logic [15:0] m_q [$];
    logic [15:0] m_cur;
    bit          m_clk;
    bit          m_data;
    bit          m_unf;
    bit          m_ovf;
    int          m_acc;
    int          m_i1;
    int          m_i2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic bit modulate(input logic [15:0] s);
`ifdef PDM_TX_ORDER2_EN
        int fb;
        fb   = m_data ? 32767 : -32768;
        m_i1 = clamp(m_i1 + int'($signed(s)) - fb, -524288, 524287);
        m_i2 = clamp(m_i2 + m_i1 - fb, -8388608, 8388607);
        return (m_i2 >= 0);
`else
        bit b;
        m_acc = m_acc + int'({16'd0, s ^ 16'h8000});
        b     = (m_acc >= 65536);
        m_acc = m_acc % 65536;
        return b;
`endif
    endfunction

    function automatic logic [31:0] m_status();
        return {22'd0, m_ovf, m_unf, 5'd0, 3'(m_q.size())};
    endfunction

    // One clock cycle: drive, check outputs against the model, advance the model.
    task automatic cycle(input bit wr, input logic [5:0] a, input logic [31:0] d);
        bit act;
        bit unf_set;
        int ph;
        int osr_eff;
        unf_set          = 1'b0;
        bus.address      = a;
        bus.data_in      = d;
        bus.data_write_n = wr ? 2'($urandom_range(0, 2)) : 2'b11;
        bus.data_read_n  = 2'b11;
        #1;
        check("uo_out", {24'd0, uo_out}, {24'd0, 5'd0, m_data, m_clk, 1'b0});
        check("irq", {31'd0, user_interrupt}, {31'd0, (m_en && m_q.size() <= 1)});
        act     = m_en && (m_period >= 2);
        osr_eff = (m_osr == 0) ? 256 : m_osr;
        if (act) begin
            ph    = m_t % m_period;
            m_clk = (ph < m_period / 2);
            if (ph == m_period / 2) begin
                if (m_bitidx == 0) begin
                    if (m_q.size() > 0) m_cur = m_q.pop_front();
                    else unf_set = 1'b1;
                end
                m_data   = modulate(m_cur);
                m_bitidx = (m_bitidx + 1) % osr_eff;
            end
            m_t++;
        end else begin
            m_t = 0; m_clk = 0; m_data = 0; m_bitidx = 0; m_cur = 16'd0;
            m_acc = 0; m_i1 = 0; m_i2 = 0;
        end
        if (wr) begin
            case (a)
                6'h00: m_en = d[0];
                6'h04: m_period = int'(d[7:0]);
                6'h08: if (m_q.size() < 4) m_q.push_back(d[15:0]); else m_ovf = 1'b1;
                6'h0C: begin
                    if (d[8]) m_unf = 1'b0;
                    if (d[9]) m_ovf = 1'b0;
                end
                6'h10: m_osr = int'(d[7:0]);
                default: ;
            endcase
        end
        if (unf_set) m_unf = 1'b1;
        @(negedge clk);
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        cycle(1'b1, a, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 6'h3F, 32'd0);
    endtask

    task automatic rd(input logic [5:0] a, input logic [31:0] exp, input string tag);
        bus.address      = a;
        bus.data_write_n = 2'b11;
        bus.data_read_n  = 2'b00;
        #1;
        check(tag, bus.data_out, exp);
        cycle(1'b0, a, 32'd0);
    endtask

    // Counts cycles with pdm_data high over exactly 256 bit periods at PERIOD=2.
    task automatic density_run(input logic [15:0] s, output int ones);
        ones = 0;
        wr(6'h08, {16'd0, s});
        wr(6'h00, 32'd1);
        for (int i = 0; i < 514; i++) begin
            if (i >= 2) ones += int'(uo_out[2]);
            cycle(1'b0, 6'h3F, 32'd0);
        end
        wr(6'h00, 32'd0);
        wr(6'h0C, 32'h300);
    endtask

    initial begin
        logic [12:0] clk_h;
        logic [12:0] dat_h;
        logic [15:0] s;
        int          ones;

        bus.address = 6'd0; bus.data_in = 32'd0;
        bus.data_write_n = 2'b11; bus.data_read_n = 2'b11;
        m_en = 0; m_period = 0; m_osr = 0; m_t = 0; m_bitidx = 0; m_cur = 16'd0;
        m_clk = 0; m_data = 0; m_unf = 0; m_ovf = 0; m_acc = 0; m_i1 = 0; m_i2 = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        #1;
        check("rst_uo_out", {24'd0, uo_out}, 32'd0);
        check("rst_irq", {31'd0, user_interrupt}, 32'd0);
        check("data_ready", {31'd0, bus.data_ready}, 32'd1);
        rd(6'h00, 32'd0, "rst_ctrl");
        rd(6'h04, 32'd0, "rst_period");
        rd(6'h0C, 32'd0, "rst_status");
        rd(6'h10, 32'd0, "rst_osr");

        // PERIOD=4, OSR=1, sample 0x0000: clock 1100 repeating, data alternates
        wr(6'h04, 32'd4);
        wr(6'h10, 32'd1);
        rd(6'h04, 32'd4, "period_rb");
        wr(6'h08, 32'h0000);
        wr(6'h00, 32'd1);
        for (int t = 0; t < 13; t++) begin
            clk_h[t] = uo_out[1];
            dat_h[t] = uo_out[2];
            cycle(1'b0, 6'h3F, 32'd0);
        end
        check("pdm_clk_pattern", {24'd0, clk_h[8:1]}, 32'h33);
`ifndef PDM_TX_ORDER2_EN
        check("pdm_data_pattern", {29'd0, dat_h[11], dat_h[7], dat_h[3]}, 32'd2);
`endif
        wr(6'h00, 32'd0);
        idle(2);
        wr(6'h0C, 32'h300);

        // Ones density extremes over 256 bits
        wr(6'h04, 32'd2);
        wr(6'h10, 32'd0);
        density_run(16'h7FFF, ones);
`ifndef PDM_TX_ORDER2_EN
        check("density_7fff", ones, 32'd510);
`endif
        density_run(16'h8000, ones);
`ifndef PDM_TX_ORDER2_EN
        check("density_8000", ones, 32'd0);
`endif

        // Overflow while disabled
        for (int i = 0; i < 5; i++) wr(6'h08, $urandom);
        rd(6'h0C, 32'h204, "ovf_status");
        check("ovf_irq", {31'd0, user_interrupt}, 32'd0);
        wr(6'h0C, 32'h200);
        rd(6'h0C, 32'h004, "ovf_clear");

        // Drain, then a single sample with OSR=2 must underflow on the second pop attempt
        wr(6'h10, 32'd1);
        wr(6'h00, 32'd1);
        idle(12);
        wr(6'h00, 32'd0);
        wr(6'h0C, 32'h300);
        s = 16'($urandom);
        wr(6'h08, {16'd0, s});
        wr(6'h10, 32'd2);
        wr(6'h04, 32'd4);
        wr(6'h00, 32'd1);
        idle(12);
        rd(6'h0C, 32'h100, "unf_status");
        rd(6'h08, {{16{s[15]}}, s}, "unf_sample");
        wr(6'h00, 32'd0);
        wr(6'h0C, 32'h300);

        // Randomized streaming with interrupt-driven refills and a mid-stream disable
        for (int r = 0; r < 4; r++) begin
            wr(6'h04, $urandom_range(2, 9));
            wr(6'h10, $urandom_range(1, 4));
            wr(6'h08, $urandom);
            wr(6'h08, $urandom);
            wr(6'h00, 32'd1);
            for (int i = 0; i < 300; i++) begin
                if (i == 150) begin
                    wr(6'h00, 32'd0);
                    rd(6'h0C, m_status(), "disabled_status");
                    idle(2);
                    wr(6'h00, 32'd1);
                end else if (i % 37 == 0) begin
                    rd(6'h08, {{16{m_cur[15]}}, m_cur}, "sample_rb");
                end else if (m_q.size() <= 1 && $urandom_range(0, 1) == 1) begin
                    wr(6'h08, $urandom);
                end else begin
                    cycle(1'b0, 6'h3F, 32'd0);
                end
            end
            rd(6'h0C, m_status(), "stream_status");
            wr(6'h00, 32'd0);
            wr(6'h0C, 32'h300);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tqvp_jnms_pdm_tx.md
# tqvp_jnms_pdm_tx

TinyQV peripheral that turns software-written 16-bit signed PCM samples into a 1-bit PDM bitstream, with a matching PDM bit clock, for driving a PDM-input amplifier or DAC. It is the transmit counterpart of the PDM microphone peripheral and uses the same clock divider scheme. Samples pass through a 4-entry FIFO and are held for a programmable number of PDM bits (oversampling ratio). A level-based interrupt requests more samples.

## Interface
- No parameters.
- clk  in  1  project clock (64 MHz nominal)
- rst_n  in  1  reset: synchronous, active-low
- ui_in  in  8  unused
- uo_out  out  8  [1] = PDM clock, [2] = PDM data, all other bits 0
- address  in  6  register address
- data_in  in  32  write data
- data_write_n  in  2  11 = no write, else write of any width
- data_read_n  in  2  11 = no read; reads have no side effects
- data_out  out  32  combinational register read data
- data_ready  out  1  constant 1
- user_interrupt  out  1  sample request

## Operation
- Registers. Reset value 0 unless noted:
  - 0x00 CTRL: bit0 enable.
  - 0x04 PERIOD[7:0]: PDM clock period in clk cycles.
  - 0x08 SAMPLE: write pushes data_in[15:0] into the FIFO. Read returns the sample being modulated, sign-extended.
  - 0x0C STATUS: [2:0] FIFO level 0..4, [8] underflow, [9] overflow. Flag bits are sticky. Writing 1 to bit 8 or bit 9 clears that flag.
  - 0x10 OSR[7:0]: PDM bits per sample. 0 means 256.
  - Other addresses read 0 and ignore writes.
- Divider (active when enable=1 and PERIOD>=2):
  - phase counts 0..PERIOD-1 and wraps.
  - pdm_clk is registered and equals (phase < PERIOD>>1).
- Inactive (enable=0 or PERIOD<2):
  - phase, pdm_clk, pdm_data, bit counter, modulator state and current sample are all held at 0.
  - uo_out[2:1] = 0.
  - The FIFO and flags keep their state, and writes are still accepted.
- Bit step: occurs in the cycle where phase==PERIOD>>1, i.e. when pdm_clk falls. In that cycle:
  - If bit counter==0: pop the FIFO head into current sample. If the FIFO is empty, set underflow and keep the current sample.
  - Run one modulator iteration and register its output bit as pdm_data.
  - Advance the bit counter modulo OSR.
- First-order modulator:
  - u = sample XOR 0x8000, as 16-bit unsigned.
  - {c, acc} = acc + u, where acc is 16 bits wide.
  - The output bit is the carry c. Ones density is u/65536.
- FIFO: 4 entries, first-in first-out.
  - A push to a full FIFO is dropped and sets overflow.
  - A push and a pop in the same cycle on a full FIFO: the push is accepted and the level stays 4.
  - A push and a pop in the same cycle on an empty FIFO: the pop underflows, then the pushed sample is stored and level becomes 1.
- user_interrupt = enable & (level <= 1). It is combinational from registered state and clears only by filling the FIFO.
- Changing PERIOD or OSR while enabled takes effect immediately. If phase or the bit counter is at or above the new value, it wraps to 0 on its next increment.

## Timing
- Reset: all registers 0; uo_out=0; data_out=0 at address 0; user_interrupt=0.
- A write updates its register on the clk edge of the write. A SAMPLE push is visible in level on the next cycle.
- After enable goes 0→1:
  - The first bit step occurs PERIOD>>1 cycles later and pops the first sample.
  - pdm_data is valid from the cycle after that step.
- pdm_data changes only on the falling edge of pdm_clk. It is stable across the following rising edge and the whole high phase.
- Duty cycle: high for PERIOD>>1 cycles, low for the remaining cycles. Odd periods give the longer phase to low.
- One PCM sample lasts OSR×PERIOD clk cycles.

## Configuration
- PDM_TX_ORDER2_EN defined: the modulator is second-order error feedback.
  - i1 is 20-bit signed and i2 is 24-bit signed. Both saturate at their limits.
  - fb = +32767 if the previous bit was 1, else −32768.
  - Each step: i1 += s − fb; i2 += i1 − fb; bit = (i2 >= 0).
  - Both integrators reset to 0.
- Macro undefined: the first-order accumulator described in Operation is used. The register map is the same in both cases.

## Test plan
- Reset → uo_out=0x00; STATUS=0; user_interrupt=0; reading 0x04 returns 0.
- PERIOD=4, OSR=1, enable, sample 0x0000 (first-order) → pdm_clk pattern is 1,1,0,0 repeating; pdm_data is 0,1,0,1 on successive falling edges.
- Sample 0x7FFF (first-order), 256 bits → 255 ones; sample 0x8000 → all zeros.
- Five SAMPLE writes while disabled → level=4, overflow=1, user_interrupt=0. Write 0x200 to STATUS → overflow=0.
- Enable with one sample, OSR=2 → after the second pop attempt, underflow=1 and SAMPLE read still returns the first sample; user_interrupt=1 throughout.
- Disable mid-stream → uo_out[2:1]=0 next cycle and level is unchanged. Re-enable → accumulator restarts from 0 and the next pop follows the FIFO order.
